// File: rtl/disc_op_sequencer.sv
// -----------------------------------------------------------------------------
// disc_op_sequencer
//
// Sequences writes into the 13 discrete-output set/reset latches. Requesters
// post (register index, set/clear) commands into a small FIFO. For each
// command the block raises a one-hot select and waits SETUP_CYC clocks. It
// then drives a DOS (set) or DOR (reset) strobe for STROBE_CYC clocks and
// holds the select for HOLD_CYC clocks. A shadow copy of all 13 latch states
// is kept for readback.
//
// Handshake: a command transfers on a rising edge where CMD_VALID and
// CMD_READY are both high. CMD_READY depends only on registered state.
// Offering an index outside 1..13 consumes the offer without queuing it and
// pulses ERR on the following cycle.
//
// Ports
//   SIM_CLK    in   sole clock, rising edge
//   SIM_RST    in   asynchronous active-low reset
//   TICK       in   one-clock word-time pulse; a command only starts on TICK
//   CMD_VALID  in   command offered
//   CMD_ADDR   in   [3:0] register index, 1..13 valid
//   CMD_SET    in   1 = set (DOS), 0 = reset (DOR)
//   CMD_READY  out  FIFO not full
//   SEL        out  [12:0] one-hot select, bit n-1 = DORn
//   DOS        out  set strobe
//   DOR        out  reset strobe
//   SHADOW     out  [12:0] current state of DOR1..DOR13
//   BUSY       out  FSM not idle or FIFO non-empty
//   ERR        out  one-clock pulse for an invalid index
//   DBG_STATE  out  [1:0] FSM state (0 IDLE, 1 SETUP, 2 STROBE, 3 HOLD)
// -----------------------------------------------------------------------------
module disc_op_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1
) (
   input  logic        SIM_CLK,
   input  logic        SIM_RST,
   input  logic        TICK,
   input  logic        CMD_VALID,
   input  logic [3:0]  CMD_ADDR,
   input  logic        CMD_SET,
   output logic        CMD_READY,
   output logic [12:0] SEL,
   output logic        DOS,
   output logic        DOR,
   output logic [12:0] SHADOW,
   output logic        BUSY,
   output logic        ERR,
   output logic [1:0]  DBG_STATE
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = 8;

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYC - 1);
   // Only loaded when HOLD_CYC > 0; guarded so it never wraps negative.
   localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [4:0]       mem_q [FIFO_DEPTH];   // {set, addr}
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ready_q, ready_d;

   logic       addr_ok;
   logic       accept;
   logic       push;
   logic       pop;
   logic [4:0] head;
   logic [12:0] head_sel;

   // ---------------------------------------------------------------- FSM
   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   // ------------------------------------------------------------ outputs
   logic [12:0] sel_q, sel_d;
   logic        dos_q, dos_d;
   logic        dor_q, dor_d;
   logic [12:0] shadow_q, shadow_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic        cur_set_q, cur_set_d;

   assign addr_ok  = (CMD_ADDR != 4'd0) && (CMD_ADDR <= 4'd13);
   assign accept   = CMD_VALID & ready_q;
   assign push     = accept & addr_ok;
   assign pop      = (state_q == S_IDLE) & TICK & (count_q != '0);
   assign head     = mem_q[rd_ptr_q];
   assign head_sel = 13'd1 << (head[3:0] - 4'd1);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      ready_d = (count_d < DEPTH_C);
   end

   // Storage has no reset; validity is tracked by the pointers and count.
   always_ff @(posedge SIM_CLK) begin
      if (push) mem_q[wr_ptr_q] <= {CMD_SET, CMD_ADDR};
   end

   // ------------------------------------------------ FSM: state register
   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // ------------------------------------------------ FSM: next state
   // One down-counter times all three phases; each phase lasts load+1 clocks.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d = S_SETUP;
               tmr_d   = SETUP_LD;
            end
         end
         S_SETUP: begin
            if (tmr_q == '0) begin
               state_d = S_STROBE;
               tmr_d   = STROBE_LD;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_STROBE: begin
            if (tmr_q == '0) begin
               if (HOLD_CYC > 0) begin
                  state_d = S_HOLD;
                  tmr_d   = HOLD_LD;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_HOLD: begin
            if (tmr_q == '0) state_d = S_IDLE;
            else             tmr_d   = tmr_q - TMR_W'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------ FSM: outputs
   always_comb begin
      sel_d     = sel_q;
      dos_d     = dos_q;
      dor_d     = dor_q;
      shadow_d  = shadow_q;
      cur_set_d = cur_set_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               sel_d     = head_sel;
               cur_set_d = head[4];
            end
         end
         S_SETUP: begin
            if (tmr_q == '0) begin
               dos_d = cur_set_q;
               dor_d = ~cur_set_q;
            end
         end
         S_STROBE: begin
            if (tmr_q == '0) begin
               dos_d = 1'b0;
               dor_d = 1'b0;
               // SEL is one-hot for the active command, so it doubles as
               // the bit mask for the shadow update.
               shadow_d = cur_set_q ? (shadow_q | sel_q) : (shadow_q & ~sel_q);
               if (HOLD_CYC == 0) sel_d = '0;
            end
         end
         S_HOLD: begin
            if (tmr_q == '0) sel_d = '0;
         end
         default: begin
            sel_d = '0;
            dos_d = 1'b0;
            dor_d = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE) || (count_d != '0);
      err_d  = accept & ~addr_ok;
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
      if (!SIM_RST) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ready_q   <= 1'b1;
         sel_q     <= '0;
         dos_q     <= 1'b0;
         dor_q     <= 1'b0;
         shadow_q  <= '0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         cur_set_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ready_q   <= ready_d;
         sel_q     <= sel_d;
         dos_q     <= dos_d;
         dor_q     <= dor_d;
         shadow_q  <= shadow_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         cur_set_q <= cur_set_d;
      end
   end

   assign CMD_READY = ready_q;
   assign SEL       = sel_q;
   assign DOS       = dos_q;
   assign DOR       = dor_q;
   assign SHADOW    = shadow_q;
   assign BUSY      = busy_q;
   assign ERR       = err_q;
   assign DBG_STATE = state_q;

endmodule
